// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the split-access load/store unit.
//   - access size encodings (SZ_B / SZ_H / SZ_W, 2'b11 is illegal)
//   - FSM state enumeration
//   - per-size byte-mask constants and the lane-mask helper
//   - default bus timeout
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam int DEFAULT_TIMEOUT_CYC = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ1  = 3'd1,
        ST_WAIT1 = 3'd2,
        ST_REQ2  = 3'd3,
        ST_WAIT2 = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    // Unshifted byte mask for an access size; the illegal size yields no lanes.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return MASK_B;
            SZ_H:    return MASK_H;
            SZ_W:    return MASK_W;
            default: return 4'b0000;
        endcase
    endfunction

    // Byte mask shifted to the access offset over two consecutive words:
    // bits [3:0] are lanes of the first word, bits [7:4] lanes of the next.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        return {4'b0000, size_mask(size)} << off;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational lane steering for lsu_split_access.
// Ports:
//   size, off, sext  : access size, byte offset addr[1:0], sign-extend flag
//   wdata            : LSB-aligned store data
//   beat1, beat2     : read data of the first and second bus word (beat2 = 0 if unsplit)
//   be1, be2         : byte enables for the first and second beat
//   split            : access touches the following word
//   wdata_rot        : store data rotated into lane position
//   rdata_ext        : assembled, truncated and extended load result
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] beat1,
    input  logic [31:0] beat2,
    output logic [3:0]  be1,
    output logic [3:0]  be2,
    output logic        split,
    output logic [31:0] wdata_rot,
    output logic [31:0] rdata_ext
);

    logic [7:0]  sh;
    logic [4:0]  bit_sh;
    logic [63:0] wd_dbl;
    logic [63:0] rd_dbl;
    logic [31:0] raw;

    assign sh     = lane_mask(size, off);
    assign be1    = sh[3:0];
    assign be2    = sh[7:4];
    assign split  = |sh[7:4];
    assign bit_sh = {off, 3'b000};

    // Rotate-left: the upper word of {x,x} << n is x rotated left by n.
    assign wd_dbl    = {wdata, wdata} << bit_sh;
    assign wdata_rot = wd_dbl[63:32];

    // Bring the addressed byte down to bit 0 across both beats.
    assign rd_dbl = {beat2, beat1} >> bit_sh;
    assign raw    = rd_dbl[31:0];

    always_comb begin
        rdata_ext = raw;
        case (size)
            SZ_B: rdata_ext = sext ? {{24{raw[7]}}, raw[7:0]}   : {24'h000000, raw[7:0]};
            SZ_H: rdata_ext = sext ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
            default: rdata_ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_split_access.sv
// lsu_split_access: multi-cycle load/store unit between execute and a
// req/gnt/rvalid data bus. One byte/half/word access at a time; accesses
// crossing a word boundary are issued as two bus beats.
// Build option: LSU_MISALIGN_EN - when defined, word-crossing accesses are
// split into two beats; when undefined they complete immediately with an
// error and no bus activity.
// Ports:
//   clk, rstn                : clock, synchronous active-low reset
//   lsu_req_i / lsu_ready_o  : request handshake (accepted when both high)
//   lsu_we_i, lsu_size_i, lsu_sext_i, lsu_addr_i, lsu_wdata_i : request fields
//   lsu_rvalid_o, lsu_rdata_o, lsu_err_o : one-cycle completion with result
//   mem_req_o / mem_gnt_i    : bus request handshake
//   mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o : bus request fields
//   mem_rvalid_i, mem_rdata_i: bus response
module lsu_split_access
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              lsu_req_i,
    output logic              lsu_ready_o,
    input  logic              lsu_we_i,
    input  logic [1:0]        lsu_size_i,
    input  logic              lsu_sext_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    output logic              lsu_rvalid_o,
    output logic [31:0]       lsu_rdata_o,
    output logic              lsu_err_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

`ifdef LSU_MISALIGN_EN
    localparam bit MISALIGN_EN = 1'b1;
`else
    localparam bit MISALIGN_EN = 1'b0;
`endif

    lsu_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              sext_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [31:0]       beat1_reg;
    logic [31:0]       beat2_reg;
    logic              err_reg;

    logic [7:0]        in_mask;
    logic              accept_err;
    logic              timeout_hit;
    logic              timeout_abort;
    logic              bus_req;
    logic [ADDR_W-1:0] word_addr;

    logic [3:0]        be1, be2;
    logic              split;
    logic [31:0]       wdata_rot;
    logic [31:0]       rdata_ext;

    lsu_lane_align u_align (
        .size      (size_reg),
        .off       (addr_reg[1:0]),
        .sext      (sext_reg),
        .wdata     (wdata_reg),
        .beat1     (beat1_reg),
        .beat2     (beat2_reg),
        .be1       (be1),
        .be2       (be2),
        .split     (split),
        .wdata_rot (wdata_rot),
        .rdata_ext (rdata_ext)
    );

    // Accept-time error check works on the raw request, before it is latched.
    assign in_mask = lane_mask(lsu_size_i, lsu_addr_i[1:0]);
    assign accept_err = (lsu_size_i == 2'b11) || (!MISALIGN_EN && (|in_mask[7:4]));

    // The counter starts at 0 on state entry, so TIMEOUT_CYC cycles are
    // spent in a state when it reads TIMEOUT_CYC-1 without progress.
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next    = state_reg;
        bus_req       = 1'b0;
        timeout_abort = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (lsu_req_i) begin
                    state_next = accept_err ? ST_RESP : ST_REQ1;
                end
            end
            ST_REQ1: begin
                bus_req = 1'b1;
                if (mem_gnt_i) begin
                    state_next = ST_WAIT1;
                end else if (timeout_hit) begin
                    state_next    = ST_RESP;
                    timeout_abort = 1'b1;
                end
            end
            ST_WAIT1: begin
                if (mem_rvalid_i) begin
                    state_next = (MISALIGN_EN && split) ? ST_REQ2 : ST_RESP;
                end else if (timeout_hit) begin
                    state_next    = ST_RESP;
                    timeout_abort = 1'b1;
                end
            end
`ifdef LSU_MISALIGN_EN
            ST_REQ2: begin
                bus_req = 1'b1;
                if (mem_gnt_i) begin
                    state_next = ST_WAIT2;
                end else if (timeout_hit) begin
                    state_next    = ST_RESP;
                    timeout_abort = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (mem_rvalid_i) begin
                    state_next = ST_RESP;
                end else if (timeout_hit) begin
                    state_next    = ST_RESP;
                    timeout_abort = 1'b1;
                end
            end
`endif
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            size_reg  <= 2'b00;
            sext_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= 32'h0;
            beat1_reg <= 32'h0;
            beat2_reg <= 32'h0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (bus_req || state_reg == ST_WAIT1 || state_reg == ST_WAIT2) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            if (state_reg == ST_IDLE && lsu_req_i) begin
                we_reg    <= lsu_we_i;
                size_reg  <= lsu_size_i;
                sext_reg  <= lsu_sext_i;
                addr_reg  <= lsu_addr_i;
                wdata_reg <= lsu_wdata_i;
                beat1_reg <= 32'h0;
                beat2_reg <= 32'h0;
                err_reg   <= accept_err;
            end

            // Responses are only taken in a WAIT state; stray ones are dropped.
            if (state_reg == ST_WAIT1 && mem_rvalid_i) begin
                beat1_reg <= mem_rdata_i;
            end
`ifdef LSU_MISALIGN_EN
            if (state_reg == ST_WAIT2 && mem_rvalid_i) begin
                beat2_reg <= mem_rdata_i;
            end
`endif
            if (timeout_abort) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign word_addr = {addr_reg[ADDR_W-1:2], 2'b00};

    assign mem_req_o   = bus_req;
    assign mem_we_o    = bus_req && we_reg;
    assign mem_addr_o  = !bus_req ? '0 :
                         (state_reg == ST_REQ2) ? word_addr + ADDR_W'(4) : word_addr;
    assign mem_be_o    = (state_reg == ST_REQ1) ? be1 :
                         (state_reg == ST_REQ2) ? be2 : 4'b0000;
    assign mem_wdata_o = bus_req ? wdata_rot : 32'h0;

    // Execute-side outputs are held low for the whole reset cycle.
    assign lsu_ready_o  = rstn && (state_reg == ST_IDLE);
    assign lsu_rvalid_o = rstn && (state_reg == ST_RESP);
    assign lsu_err_o    = rstn && (state_reg == ST_RESP) && err_reg;
    assign lsu_rdata_o  = (lsu_rvalid_o && !err_reg && !we_reg) ? rdata_ext : 32'h0;

endmodule
